// File: rtl/mdu_ctrl_if.sv
// Request/response bundle between the EX-stage issue logic and the multiply/divide sequencer.
// The master drives requests and flush; the slave returns busy/done status and the HI/LO registers.
interface mdu_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, flush,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, flush,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; WIDTH busy cycles, done in cycle N+WIDTH+1.
// No ready handshake: starts arriving while busy are dropped, so the hazard unit must stall on busy.
module mdu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  mdu_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rs_neg_q, rs_neg_d;
  logic               dz_q, dz_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               sgn, rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] mul_step, div_step, step, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               idle_like, accept_mdu, accept_mt;

  // Operand conditioning: signed ops (op[0]==0) iterate on magnitudes.
  always_comb begin
    sgn    = ~bus.op[0];
    rs_neg = sgn & bus.rs_val[WIDTH-1];
    rt_neg = sgn & bus.rt_val[WIDTH-1];
    rs_mag = rs_neg ? -bus.rs_val : bus.rs_val;
    rt_mag = rt_neg ? -bus.rt_val : bus.rt_val;
  end

  // acc_q holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    mul_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    div_step = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    step     = is_div_q ? div_step : mul_step;
    prod_fix = neg_q ? -step : step;
    // A zero divisor leaves the dividend magnitude as remainder, so the sign fix restores rs_val.
    quo_fix  = dz_q ? '1 : (neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0]);
    rem_fix  = rs_neg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rs_neg_d   = rs_neg_q;
    dz_d       = dz_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    idle_like  = (state_q != S_BUSY);
    accept_mdu = idle_like & bus.start & ~bus.flush & ~bus.op[2];
    accept_mt  = idle_like & bus.start & ~bus.flush &
                 ((bus.op == OP_MTHI) | (bus.op == OP_MTLO));

    case (state_q)
      S_BUSY: begin
        if (bus.flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = S_DONE;
            if (is_div_q) begin
              hi_d       = rem_fix;
              lo_d       = quo_fix;
              div_zero_d = dz_q;
            end else begin
              hi_d = prod_fix[2*WIDTH-1:WIDTH];
              lo_d = prod_fix[WIDTH-1:0];
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept_mdu) begin
      state_d    = S_BUSY;
      cnt_d      = CW'(WIDTH);
      is_div_d   = bus.op[1];
      neg_d      = rs_neg ^ rt_neg;
      rs_neg_d   = rs_neg;
      dz_d       = bus.op[1] & (bus.rt_val == '0);
      div_zero_d = 1'b0;
      opnd_d     = bus.op[1] ? rt_mag : rs_mag;
      acc_d      = {{WIDTH{1'b0}}, (bus.op[1] ? rs_mag : rt_mag)};
    end

    if (accept_mt) begin
      if (bus.op[0]) lo_d = bus.rs_val;
      else           hi_d = bus.rs_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rs_neg_q   <= 1'b0;
      dz_q       <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rs_neg_q   <= rs_neg_d;
      dz_q       <= dz_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign bus.busy     = (state_q == S_BUSY);
  assign bus.done     = (state_q == S_DONE);
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed and randomized bench for mdu_ctrl; expected HI/LO come from 64-bit integer arithmetic.
module tb_mdu_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_ctrl_if #(.WIDTH(W)) bus ();
  mdu_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_hi = '0, exp_lo = '0;
  logic        exp_dz = 1'b0;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_dz;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Architectural result of an MDU op, straight from integer arithmetic.
  task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = 64'($signed(a));
    sb = 64'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    pend_dz = 1'b0;
    case (o)
      3'd0: begin p = sa * sb; pend_hi = p[63:32]; pend_lo = p[31:0]; end
      3'd1: begin p = ua * ub; pend_hi = p[63:32]; pend_lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          pend_dz = 1'b1; pend_hi = a; pend_lo = 32'hFFFF_FFFF;
        end else if (o == 3'd2) begin
          sq = sa / sb; sr = sa % sb;
          pend_lo = sq[31:0]; pend_hi = sr[31:0];
        end else begin
          p = ua / ub; pend_lo = p[31:0];
          p = ua % ub; pend_hi = p[31:0];
        end
      end
    endcase
    exp_dz = 1'b0;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.op     = o;
    bus.rs_val = a;
    bus.rt_val = b;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  // Entered at the negedge of busy cycle cyc0; returns at the negedge of the done cycle.
  task automatic wait_done(input string tag, input int cyc0);
    int cyc, nbusy;
    cyc = cyc0;
    nbusy = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.busy === 1'b1) nbusy++;
      @(negedge clk);
      cyc++;
    end
    exp_hi = pend_hi; exp_lo = pend_lo; exp_dz = pend_dz;
    chk({tag, ":latency"}, 64'(cyc), 64'd33);
    chk({tag, ":busy_cycles"}, 64'(nbusy), 64'(33 - cyc0));
    chk({tag, ":busy_in_done"}, 64'(bus.busy), 64'd0);
    chk({tag, ":hi"}, 64'(bus.hi), 64'(exp_hi));
    chk({tag, ":lo"}, 64'(bus.lo), 64'(exp_lo));
    chk({tag, ":div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    model_op(o, a, b);
    issue(o, a, b);
    wait_done(tag, 1);
  endtask

  task automatic mt(input string tag, input logic [2:0] o, input logic [31:0] a);
    issue(o, a, $urandom);
    if (o == 3'd4) exp_hi = a;
    else           exp_lo = a;
    chk({tag, ":done"}, 64'(bus.done), 64'd0);
    chk({tag, ":busy"}, 64'(bus.busy), 64'd0);
    chk({tag, ":hi"}, 64'(bus.hi), 64'(exp_hi));
    chk({tag, ":lo"}, 64'(bus.lo), 64'(exp_lo));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    logic [2:0] o;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 3'd0; bus.rs_val = '0; bus.rt_val = '0; bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst:busy", 64'(bus.busy), 64'd0);
    chk("rst:done", 64'(bus.done), 64'd0);
    chk("rst:div_zero", 64'(bus.div_zero), 64'd0);
    chk("rst:hi", 64'(bus.hi), 64'd0);
    chk("rst:lo", 64'(bus.lo), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("done_pulse_width", 64'(bus.done), 64'd0);

    run("mult_m3x7", 3'd0, 32'hFFFF_FFFD, 32'd7);
    run("mult_b2b", 3'd0, 32'd12345, 32'hFFFF_FD5A);
    run("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2);
    run("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run("divu_by0", 3'd3, 32'd5, 32'd0);
    run("divu_9_4", 3'd3, 32'd9, 32'd4);
    run("div_neg_by0", 3'd2, 32'hFFFF_FF00, 32'd0);
    run("mult_min_min", 3'd0, 32'h8000_0000, 32'h8000_0000);
    @(negedge clk);

    mt("mtlo", 3'd5, 32'h0000_1234);
    mt("mthi", 3'd4, 32'hCAFE_F00D);

    // Starts issued while busy must leave the in-flight result and HI intact.
    model_op(3'd0, 32'hFFFF_F000, 32'd77);
    issue(3'd0, 32'hFFFF_F000, 32'd77);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd4; bus.rs_val = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.op = 3'd3; bus.rs_val = 32'd100; bus.rt_val = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("start_in_busy", 7);
    @(negedge clk);

    // Flush in the 10th busy cycle: back to idle, registers untouched, no done.
    model_op(3'd2, 32'd1000, 32'd7);
    issue(3'd2, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    chk("flush:busy_before", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush:busy_after", 64'(bus.busy), 64'd0);
    chk("flush:done", 64'(bus.done), 64'd0);
    chk("flush:hi", 64'(bus.hi), 64'(exp_hi));
    chk("flush:lo", 64'(bus.lo), 64'(exp_lo));
    chk("flush:div_zero", 64'(bus.div_zero), 64'(exp_dz));
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) nd++;
    end
    chk("flush:no_done", 64'(nd), 64'd0);

    // Flush together with start in idle drops the start.
    bus.flush = 1'b1;
    issue(3'd1, 32'd3, 32'd3);
    bus.flush = 1'b0;
    chk("flush_start:busy", 64'(bus.busy), 64'd0);
    chk("flush_start:lo", 64'(bus.lo), 64'(exp_lo));

    // Reserved opcodes change nothing.
    issue(3'd6, 32'h1111_1111, 32'd2);
    chk("op110:busy", 64'(bus.busy), 64'd0);
    issue(3'd7, 32'h2222_2222, 32'd2);
    chk("op111:busy", 64'(bus.busy), 64'd0);
    chk("op11x:hi", 64'(bus.hi), 64'(exp_hi));
    chk("op11x:lo", 64'(bus.lo), 64'(exp_lo));

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 5));
      if (o < 3'd4) run($sformatf("rnd%0d_op%0d", i, o), o, pick(), pick());
      else          mt($sformatf("rnd%0d_mt%0d", i, o), o, $urandom);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    // Asynchronous reset mid-operation.
    run("pre_rst", 3'd3, 32'd17, 32'd0);
    issue(3'd0, 32'd123, 32'd456);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
    chk("rst_mid:busy", 64'(bus.busy), 64'd0);
    chk("rst_mid:done", 64'(bus.done), 64'd0);
    chk("rst_mid:hi", 64'(bus.hi), 64'd0);
    chk("rst_mid:lo", 64'(bus.lo), 64'd0);
    chk("rst_mid:div_zero", 64'(bus.div_zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run("post_rst", 3'd2, 32'hFFFF_FF9C, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
